alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that sequences the shared 8-bit adder ALU to compute an unsigned 8x8 -> 16-bit product by shift-and-add.
- Sits between a requester (Start/Done handshake) and the ALU instance.
- Drives the ALU operands each cycle, consumes its 8-bit Result, and derives the carry internally.

Parameters:
- WIDTH, 8, operand width; ALU width; product is 2*WIDTH. Only 8 is verified.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- Start  input  1  request; sampled only in IDLE
- MulA  input  WIDTH  multiplicand; latched on an accepted Start
- MulB  input  WIDTH  multiplier; latched on an accepted Start
- Busy  output  1  high while in CALC
- Done  output  1  one-cycle pulse when Product becomes valid
- Product  output  2*WIDTH  result; held until the next accepted Start
- AluA  output  WIDTH  to ALU NumA
- AluB  output  WIDTH  to ALU NumB
- AluOp  output  1  to ALU ALUOP; constant 0 (add)
- AluResult  input  WIDTH  from ALU Result (combinational sum)

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous, active-high.
  - Reset takes priority over all other events, including mid-CALC.
  - Reset values: state=IDLE, Busy=0, Done=0, Product=0, count=0, internal registers=0.
  - AluA and AluB read 0 while in reset and IDLE.
- Internal registers:
  - M (WIDTH): latched MulA.
  - Hi (WIDTH): upper partial product.
  - Lo (WIDTH): starts as MulB and is shifted right.
  - count (3 bits).
- State IDLE:
  - Busy=0.
  - Start=1 at edge t: M<=MulA, Hi<=0, Lo<=MulB, count<=0, go to CALC.
  - Product is not cleared on Start; it keeps its old value until the DONE update.
- State CALC (exactly WIDTH cycles):
  - Busy=1.
  - Operand drive: AluA=Hi; AluB=M when Lo[0]=1, else 0.
  - Carry: C = (AluResult < AluA), unsigned compare.
  - Edge update: {Hi,Lo} <= {C, AluResult, Lo[WIDTH-1:1]} taken as the upper 2*WIDTH bits, i.e. Hi<={C,AluResult[7:1]}, Lo<={AluResult[0],Lo[7:1]}.
  - count<=count+1.
  - When count==WIDTH-1 at an edge, go to DONE.
  - Start is ignored in CALC. MulA/MulB changes have no effect.
- State DONE (1 cycle):
  - On entry edge: Product<={Hi,Lo}.
  - During this cycle: Done=1, Busy=0.
  - Next edge: go to IDLE.
  - Start is ignored in DONE; it is accepted at the earliest in the following IDLE cycle.
- Latency:
  - Start accepted at edge t; CALC occupies cycles t+1..t+8.
  - Done=1 and Product valid in cycle t+9.
  - Minimum Start-to-Start spacing is 10 cycles.
- Arithmetic:
  - Unsigned only. Carry is never lost.
  - 0xFF*0xFF must give 0xFE01 with no overflow.
- AluOp is held at 0 in every state.

Test Plan:
- Reset, then Start with MulA=0x0D, MulB=0x0B -> Busy high for cycles t+1..t+8; Done pulse in cycle t+9 only; Product=0x008F.
- MulA=0xFF, MulB=0xFF -> Product=0xFE01. Checks carry path: AluResult < AluA on overflowing adds.
- MulA=0x00, MulB=0x5A -> Product=0x0000. Then MulA=0x80, MulB=0x02 -> Product=0x0100.
- Start=0x12*0x34, then Start pulsed again with 0x00*0x00 during CALC cycle t+3 and during the DONE cycle:
  - first result 0x03A8 delivered;
  - second Start ignored;
  - Product stays 0x03A8 and no extra Done.
- Start 0xFF*0xFF, assert reset in CALC cycle t+4 -> next cycle Busy=0, Done=0, Product=0x0000, AluA=AluB=0.
  - A fresh Start 0x03*0x05 then yields Product=0x000F at +9.
- Monitor every cycle:
  - AluOp==0;
  - AluB ∈ {0, M};
  - Done is never high for two consecutive cycles;
  - Busy and Done are never both high.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller: drives an external WIDTH-bit adder for
// WIDTH cycles and returns an unsigned 2*WIDTH-bit product with a Done pulse.
module alu_mul_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   MulA,
    input  logic [WIDTH-1:0]   MulB,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product,
    output logic [WIDTH-1:0]   AluA,
    output logic [WIDTH-1:0]   AluB,
    output logic               AluOp,
    input  logic [WIDTH-1:0]   AluResult
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic                 carry;
    logic [WIDTH-1:0]     step_hi;
    logic [WIDTH-1:0]     step_lo;

    // Adder operands: accumulate M into Hi only when the current multiplier bit is set.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (state_q == S_CALC) begin
            alu_a = hi_q;
            alu_b = lo_q[0] ? m_q : '0;
        end
    end

    // The adder only returns WIDTH bits; a wrapped sum is smaller than either addend.
    always_comb begin
        carry   = (AluResult < alu_a);
        step_hi = {carry, AluResult[WIDTH-1:1]};
        step_lo = {AluResult[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = done_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (Start) begin
                    m_d     = MulA;
                    hi_d    = '0;
                    lo_d    = MulB;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
                    product_d = {step_hi, step_lo};
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // Operands are forced quiet while reset is asserted, even mid-calculation.
    assign AluA    = reset ? '0 : alu_a;
    assign AluB    = reset ? '0 : alu_b;
    assign AluOp   = 1'b0;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: table vectors, corner-case
// sequences and random operands against a plain a*b reference.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_op;
    logic [7:0]  alu_result;

    int checks = 0;
    int errors = 0;

    logic        mon_en = 1'b0;
    logic        done_prev = 1'b0;
    logic [7:0]  cur_m = 8'h00;
    logic [15:0] prev_product = 16'h0000;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t tbl[6];

    alu_mul_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (start),
        .MulA      (mul_a),
        .MulB      (mul_b),
        .Busy      (busy),
        .Done      (done),
        .Product   (product),
        .AluA      (alu_a),
        .AluB      (alu_b),
        .AluOp     (alu_op),
        .AluResult (alu_result)
    );

    // The shared adder ALU: 8-bit wrapping sum.
    assign alu_result = alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge of t+10.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        start = 1'b1;
        mul_a = a;
        mul_b = b;
        cur_m = a;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            mul_a = 8'($urandom);
            mul_b = 8'($urandom);
            check("calc_busy", {31'b0, busy}, 32'd1);
            check("calc_done", {31'b0, done}, 32'd0);
            check("calc_product_held", {16'b0, product}, {16'b0, prev_product});
            @(negedge clk);
        end
        check("done_pulse", {31'b0, done}, 32'd1);
        check("done_busy", {31'b0, busy}, 32'd0);
        check("product", {16'b0, product}, {16'b0, exp});
        @(negedge clk);
        check("done_end", {31'b0, done}, 32'd0);
        check("product_hold", {16'b0, product}, {16'b0, exp});
        prev_product = exp;
    endtask

    // Every-cycle invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            check("aluop_zero", {31'b0, alu_op}, 32'd0);
            checks++;
            if (!(alu_b == 8'h00 || alu_b == cur_m)) begin
                errors++;
                $display("FAIL alub_range actual=%0h required=0_or_%0h", alu_b, cur_m);
            end
            checks++;
            if (done && done_prev) begin
                errors++;
                $display("FAIL done_twice actual=1 required=0");
            end
            checks++;
            if (done && busy) begin
                errors++;
                $display("FAIL busy_and_done actual=1 required=0");
            end
            if (!busy && !done) begin
                check("idle_alua", {24'b0, alu_a}, 32'd0);
                check("idle_alub", {24'b0, alu_b}, 32'd0);
            end
            done_prev = done;
        end
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        tbl[0] = '{a: 8'h0D, b: 8'h0B, p: 16'h008F};
        tbl[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
        tbl[2] = '{a: 8'h00, b: 8'h5A, p: 16'h0000};
        tbl[3] = '{a: 8'h80, b: 8'h02, p: 16'h0100};
        tbl[4] = '{a: 8'h01, b: 8'hFF, p: 16'h00FF};
        tbl[5] = '{a: 8'hFF, b: 8'h01, p: 16'h00FF};

        reset = 1'b1;
        start = 1'b0;
        mul_a = 8'h00;
        mul_b = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_product", {16'b0, product}, 32'd0);
        check("rst_alua", {24'b0, alu_a}, 32'd0);
        check("rst_alub", {24'b0, alu_b}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_mul(tbl[i].a, tbl[i].b, tbl[i].p);

        // Start pulses in CALC (t+3) and in DONE (t+9) must both be ignored.
        start = 1'b1; mul_a = 8'h12; mul_b = 8'h34; cur_m = 8'h12;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; mul_a = 8'h00; mul_b = 8'h00;
        check("ign_busy_t3", {31'b0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("ign_done_t9", {31'b0, done}, 32'd1);
        check("ign_product", {16'b0, product}, 32'h03A8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("ign_no_busy", {31'b0, busy}, 32'd0);
            check("ign_no_done", {31'b0, done}, 32'd0);
            check("ign_product_hold", {16'b0, product}, 32'h03A8);
            @(negedge clk);
        end
        prev_product = 16'h03A8;

        // Reset asserted during CALC cycle t+4.
        start = 1'b1; mul_a = 8'hFF; mul_b = 8'hFF; cur_m = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_product", {16'b0, product}, 32'd0);
        check("midrst_alua", {24'b0, alu_a}, 32'd0);
        check("midrst_alub", {24'b0, alu_b}, 32'd0);
        reset = 1'b0;
        prev_product = 16'h0000;
        run_mul(8'h03, 8'h05, 16'h000F);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_mul(ra, rb, 16'(ra) * 16'(rb));
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
